nios_keys_pio: RTL and testbench
================================

NIOS_KEYS_PIO -- requirements
Module: nios_keys_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of input bits, 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles required to accept a change, >=1.
REQ-003 SHALL have parameter EDGE_TYPE, default 1: edge that sets edgecapture; 0 rising, 1 falling, 2 any.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port address  input  2  register select: 0 data, 2 interruptmask, 3 edgecapture; 1 reserved.
REQ-007 SHALL have port chipselect  input  1  slave select.
REQ-008 SHALL have port write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 SHALL have port writedata  input  32  write data; bits above WIDTH-1 ignored.
REQ-010 SHALL have port in_port  input  WIDTH  asynchronous raw inputs (keys/switches).
REQ-011 SHALL have port readdata  output  32  registered read data, zero-extended.
REQ-012 SHALL have port irq  output  1  level interrupt request, active-high.

Function
REQ-013 SHALL pass in_port through a 2-flop synchronizer per bit (sync1, sync2) before any other use.
REQ-014 SHALL keep per bit a debounced value "stable" and a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-015 SHALL, when sync2 equals stable, clear the bit's counter to 0.
REQ-016 SHALL, when sync2 differs from stable and counter < DEBOUNCE_CYCLES-1, increment the counter.
REQ-017 SHALL, when sync2 differs from stable and counter == DEBOUNCE_CYCLES-1, load stable <= sync2 and clear the counter in the same cycle.
REQ-018 SHALL therefore update stable exactly DEBOUNCE_CYCLES+2 clocks after a clean in_port change; a glitch shorter than DEBOUNCE_CYCLES cycles at sync2 SHALL leave stable unchanged.
REQ-019 SHALL set edgecapture[i] on the same clock edge that stable[i] updates, if the transition matches EDGE_TYPE (0->1 rising, 1->0 falling, either for 2).
REQ-020 SHALL hold edgecapture bits set until cleared by software; bits are sticky.
REQ-021 SHALL, on chipselect=1, write_n=0, address=3, clear every edgecapture[i] with writedata[i]=1 (write-1-to-clear); bits written 0 unchanged.
REQ-022 SHALL, when a set event and a write-1-clear hit the same bit in the same cycle, leave the bit set (set wins).
REQ-023 SHALL, on chipselect=1, write_n=0, address=2, load interruptmask <= writedata[WIDTH-1:0].
REQ-024 SHALL ignore writes to addresses 0 and 1.
REQ-025 SHALL drive irq = OR over i of (edgecapture[i] AND interruptmask[i]), decoded from registers, no added delay.
REQ-026 SHALL register readdata every clock (read latency 1): address 0 -> stable, 2 -> interruptmask, 3 -> edgecapture, 1 -> 0; upper bits 0.
REQ-027 SHALL produce readdata from register values before any same-cycle write takes effect.

Reset
REQ-028 SHALL, while reset=1 at a clock edge, clear sync1, sync2, counters, edgecapture, interruptmask and readdata to 0; irq SHALL be 0 the cycle after.
REQ-029 SHALL load stable to all ones at reset (idle level of active-low keys); a mid-debounce reset SHALL discard the partial count and record no edge.
REQ-030 SHALL ignore bus writes in any cycle reset=1.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1)
REQ-031 SHALL cover: reset, in_port=4'hF held -> read addr 0 returns 0x0000000F, addr 3 returns 0, irq=0.
REQ-032 SHALL cover: in_port 4'hF->4'hE clean -> stable[0] falls exactly 6 clocks later, edgecapture=0x1 same edge; mask=0x1 -> irq=1.
REQ-033 SHALL cover: in_port[1] low for 3 cycles then high -> stable, edgecapture unchanged, irq stays 0.
REQ-034 SHALL cover: edgecapture=0x3, write addr 3 data 0x1 -> edgecapture=0x2; write 0x2 coinciding with new bit-1 falling edge -> bit 1 stays 1.
REQ-035 SHALL cover: edgecapture=0x4, mask 0x0 -> irq=0; write mask 0x4 -> irq=1 next cycle; write-1-clear bit 2 -> irq=0.
REQ-036 SHALL cover: reset asserted 2 cycles into a 4-cycle debounce of in_port[3] -> after release stable=0xF, edgecapture=0, full debounce restarts.

Source files
------------

// File: rtl/nios_keys_pio.sv
// Avalon-MM PIO for debounced key/switch inputs: synchronizer, per-bit debounce,
// sticky edge capture with write-1-to-clear, interrupt mask and level irq.
module nios_keys_pio #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_RSVD = 2'd1,
        REG_MASK = 2'd2,
        REG_EDGE = 2'd3
    } reg_addr_e;

    reg_addr_e         reg_sel;
    logic              wr_en;
    logic [WIDTH-1:0]  sync1;
    logic [WIDTH-1:0]  sync2;
    logic [WIDTH-1:0]  stable;
    logic [WIDTH-1:0]  irq_mask;
    logic [WIDTH-1:0]  edge_capture;
    logic [WIDTH-1:0]  accept;
    logic [WIDTH-1:0]  set_edge;
    logic [WIDTH-1:0]  clr_edge;
    logic [CW-1:0]     cnt [WIDTH];
    logic              unused_wdata;

    assign reg_sel      = reg_addr_e'(address);
    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    // A bit is accepted on the last cycle of a full run of disagreeing samples.
    always_comb begin
        accept   = '0;
        set_edge = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
            case (EDGE_TYPE)
                0:       set_edge[i] = accept[i] &&  sync2[i];
                1:       set_edge[i] = accept[i] && !sync2[i];
                default: set_edge[i] = accept[i];
            endcase
        end
    end

    always_comb begin
        clr_edge = '0;
        if (wr_en && reg_sel == REG_EDGE) begin
            clr_edge = writedata[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '1;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Set term is OR-ed after the clear so a coincident event keeps the bit set.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_capture <= '0;
            irq_mask     <= '0;
            readdata     <= '0;
        end else begin
            edge_capture <= (edge_capture & ~clr_edge) | set_edge;
            if (wr_en && reg_sel == REG_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            case (reg_sel)
                REG_DATA: readdata <= 32'(stable);
                REG_MASK: readdata <= 32'(irq_mask);
                REG_EDGE: readdata <= 32'(edge_capture);
                default:  readdata <= '0;
            endcase
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_keys_pio.sv
// Directed self-checking bench for nios_keys_pio (WIDTH=4, DEBOUNCE_CYCLES=4, falling edges).
module tb_nios_keys_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    nios_keys_pio #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .EDGE_TYPE(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        address = a;
        tick();
        v = readdata;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        in_port    = 4'hF;
        address    = 2'd2;
        writedata  = 32'hF;
        chipselect = 1'b1;
        write_n    = 1'b0;
        idle(3);
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b expected 0", irq);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        reset      = 1'b0;
        idle(4);
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0000000F) begin
            errors++;
            $display("FAIL reset_data: got %h expected %h", rd, 32'hF);
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_edgecap: got %h expected %h", rd, 32'h0);
        end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_write_ignored_mask: got %h expected %h", rd, 32'h0);
        end
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_reserved: got %h expected %h", rd, 32'h0);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq_after: got %b expected 0", irq);
        end
    endtask

    task automatic test_glitch();
        bus_write(2'd2, 32'h2);
        in_port = 4'hD;
        idle(3);
        in_port = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks++;
            if (irq !== 1'b0) begin
                errors++;
                $display("FAIL glitch_irq cycle %0d: got %b expected 0", k, irq);
            end
        end
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'hF) begin
            errors++;
            $display("FAIL glitch_data: got %h expected %h", rd, 32'hF);
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL glitch_edgecap: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_debounce();
        logic        exp_irq;
        logic [31:0] exp_rd;
        bus_write(2'd2, 32'h1);
        address = 2'd0;
        in_port = 4'hE;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_irq = (k >= 6);
            exp_rd  = (k >= 7) ? 32'hE : 32'hF;
            checks++;
            if (irq !== exp_irq) begin
                errors++;
                $display("FAIL debounce_irq edge %0d: got %b expected %b", k, irq, exp_irq);
            end
            checks++;
            if (readdata !== exp_rd) begin
                errors++;
                $display("FAIL debounce_data edge %0d: got %h expected %h", k, readdata, exp_rd);
            end
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL debounce_edgecap: got %h expected %h", rd, 32'h1);
        end
    endtask

    task automatic test_w1c();
        in_port = 4'hC;
        idle(8);
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h3) begin
            errors++;
            $display("FAIL w1c_setup: got %h expected %h", rd, 32'h3);
        end
        bus_write(2'd3, 32'h1);
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL w1c_clear_bit0: got %h expected %h", rd, 32'h2);
        end
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL w1c_clear_bit1: got %h expected %h", rd, 32'h0);
        end
        in_port = 4'hE;
        idle(8);
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL w1c_rising_ignored: got %h expected %h", rd, 32'h0);
        end
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'hE) begin
            errors++;
            $display("FAIL w1c_data: got %h expected %h", rd, 32'hE);
        end
        in_port = 4'hC;
        idle(5);
        bus_write(2'd3, 32'h2);
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL w1c_set_wins: got %h expected %h", rd, 32'h2);
        end
    endtask

    task automatic test_irq_mask();
        bus_write(2'd3, 32'hF);
        bus_write(2'd2, 32'h0);
        in_port = 4'h8;
        idle(8);
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h4) begin
            errors++;
            $display("FAIL irqmask_edgecap: got %h expected %h", rd, 32'h4);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irqmask_masked: got %b expected 0", irq);
        end
        bus_write(2'd2, 32'h4);
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL irqmask_enabled: got %b expected 1", irq);
        end
        bus_write(2'd3, 32'h4);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irqmask_cleared: got %b expected 0", irq);
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL irqmask_edgecap_after: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        bus_write(2'd2, 32'hFFFF_FFF5);
        checks++;
        if (readdata !== 32'h4) begin
            errors++;
            $display("FAIL b2b_read_before_write: got %h expected %h", readdata, 32'h4);
        end
        bus_write(2'd2, 32'hA);
        checks++;
        if (readdata !== 32'h5) begin
            errors++;
            $display("FAIL b2b_upper_bits_ignored: got %h expected %h", readdata, 32'h5);
        end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'hA) begin
            errors++;
            $display("FAIL b2b_mask: got %h expected %h", rd, 32'hA);
        end
        bus_write(2'd0, 32'h0);
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h8) begin
            errors++;
            $display("FAIL b2b_data_write_ignored: got %h expected %h", rd, 32'h8);
        end
        bus_write(2'd1, 32'hF);
        bus_read(2'd1, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL b2b_reserved: got %h expected %h", rd, 32'h0);
        end
        bus_read(2'd2, rd);
        checks++;
        if (rd !== 32'hA) begin
            errors++;
            $display("FAIL b2b_mask_kept: got %h expected %h", rd, 32'hA);
        end
    endtask

    task automatic test_reset_mid_debounce();
        in_port = 4'hF;
        idle(8);
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL midrst_setup_edgecap: got %h expected %h", rd, 32'h0);
        end
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'hF) begin
            errors++;
            $display("FAIL midrst_setup_data: got %h expected %h", rd, 32'hF);
        end
        in_port = 4'h7;
        idle(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL midrst_irq: got %b expected 0", irq);
        end
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_readdata: got %h expected %h", readdata, 32'h0);
        end
        address = 2'd3;
        tick();
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL midrst_edgecap: got %h expected %h", readdata, 32'h0);
        end
        address = 2'd0;
        tick();
        checks++;
        if (readdata !== 32'hF) begin
            errors++;
            $display("FAIL midrst_stable: got %h expected %h", readdata, 32'hF);
        end
        idle(8);
        bus_read(2'd0, rd);
        checks++;
        if (rd !== 32'h7) begin
            errors++;
            $display("FAIL midrst_redebounced: got %h expected %h", rd, 32'h7);
        end
        bus_read(2'd3, rd);
        checks++;
        if (rd !== 32'h8) begin
            errors++;
            $display("FAIL midrst_edge_after: got %h expected %h", rd, 32'h8);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 4'hF;
        test_reset();
        test_glitch();
        test_debounce();
        test_w1c();
        test_irq_mask();
        test_back_to_back();
        test_reset_mid_debounce();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
